// File: rtl/phy_mgmt_if.sv
// ---------------------------------------------------------------------------
// phy_mgmt_if
// Command/response bundle between a management client and phy_mgmt_ctrl.
//   cmdValidIn/cmdReadyOut : command handshake, accepted when both are high
//   cmdWriteIn             : 1 = write, 0 = read
//   cmdPhyAddrIn           : 5-bit PHY address
//   cmdRegAddrIn           : 5-bit register address
//   cmdWrDataIn            : 16-bit write data
//   rdDataOut              : 16-bit result of the last completed read
//   rdValidOut             : one-cycle pulse when a read completes
//   doneOut                : one-cycle pulse when any command completes
// Modports: slave (the controller), master (the client).
// ---------------------------------------------------------------------------
interface phy_mgmt_if;
  logic        cmdValidIn;
  logic        cmdReadyOut;
  logic        cmdWriteIn;
  logic [4:0]  cmdPhyAddrIn;
  logic [4:0]  cmdRegAddrIn;
  logic [15:0] cmdWrDataIn;
  logic [15:0] rdDataOut;
  logic        rdValidOut;
  logic        doneOut;

  modport slave (
    input  cmdValidIn, cmdWriteIn, cmdPhyAddrIn, cmdRegAddrIn, cmdWrDataIn,
    output cmdReadyOut, rdDataOut, rdValidOut, doneOut
  );

  modport master (
    output cmdValidIn, cmdWriteIn, cmdPhyAddrIn, cmdRegAddrIn, cmdWrDataIn,
    input  cmdReadyOut, rdDataOut, rdValidOut, doneOut
  );
endinterface

// File: rtl/phy_mgmt_ctrl.sv
// ---------------------------------------------------------------------------
// phy_mgmt_ctrl
// Ethernet PHY management: sequences the PHY hardware reset after the clock
// generator locks, then runs clause-22 MDIO read/write frames on request.
// Ports:
//   clkIn, rstIn   : system clock, synchronous active-high reset
//   mmcmLockedIn   : clock generator locked; low restarts the reset sequence
//   intBIn/intOut  : async active-low PHY interrupt in, synchronized
//                    active-high interrupt out
//   phyRstBOut     : active-low PHY hardware reset
//   mdClkOut       : MDC
//   mdioOut/mdioOeOut/mdioIn : MDIO pad drive value, enable and input
//   phyReadyOut    : PHY out of reset and post-reset wait elapsed
//   cmdBus         : command/response bundle (phy_mgmt_if.slave)
// ---------------------------------------------------------------------------
module phy_mgmt_ctrl #(
  parameter int CLK_DIV         = 50,
  parameter int RST_HOLD_CYCLES = 2500000,
  parameter int RST_WAIT_CYCLES = 12500000
) (
  input  logic         clkIn,
  input  logic         rstIn,
  input  logic         mmcmLockedIn,
  input  logic         intBIn,
  output logic         phyRstBOut,
  output logic         mdClkOut,
  output logic         mdioOut,
  output logic         mdioOeOut,
  input  logic         mdioIn,
  output logic         phyReadyOut,
  output logic         intOut,
  phy_mgmt_if.slave    cmdBus
);

  localparam int              DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [31:0]     HOLD_LAST = 32'(RST_HOLD_CYCLES - 1);
  localparam logic [31:0]     WAIT_LAST = 32'(RST_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {RST_HOLD, RST_WAIT, IDLE, PREAMBLE, FRAME, DONE} state_t;

  state_t           state, nextState;
  logic [31:0]      rstCnt;
  logic [DIV_W-1:0] mdcCnt;
  logic [4:0]       bitCnt;
  logic [31:0]      frameSr;
  logic [15:0]      rdSr;
  logic             isRead;
  logic [1:0]       intSync;

  logic mdcTick, mdcFall, mdcRise, cmdAccept;

  // MDC toggles when the divider wraps; a toggle from high is a falling edge.
  assign mdcTick   = (mdcCnt == DIV_LAST);
  assign mdcFall   = mdcTick & mdClkOut;
  assign mdcRise   = mdcTick & ~mdClkOut;
  assign cmdAccept = cmdBus.cmdValidIn & cmdBus.cmdReadyOut;

  assign phyRstBOut         = (state != RST_HOLD);
  assign phyReadyOut        = (state != RST_HOLD) && (state != RST_WAIT);
  assign cmdBus.cmdReadyOut = (state == IDLE);
  assign cmdBus.doneOut     = (state == DONE);
  assign cmdBus.rdValidOut  = (state == DONE) && isRead;
  assign intOut             = ~intSync[1];

  always_ff @(posedge clkIn) begin
    if (rstIn) state <= RST_HOLD;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (!mmcmLockedIn) begin
      nextState = RST_HOLD;
    end else begin
      unique case (state)
        RST_HOLD: if (rstCnt == HOLD_LAST) nextState = RST_WAIT;
        RST_WAIT: if (rstCnt == WAIT_LAST) nextState = IDLE;
        IDLE:     if (cmdAccept) nextState = PREAMBLE;
        PREAMBLE: if (mdcFall && bitCnt == 5'd31) nextState = FRAME;
        FRAME:    if (mdcFall && bitCnt == 5'd31) nextState = DONE;
        DONE:     nextState = IDLE;
        default:  nextState = RST_HOLD;
      endcase
    end
  end

  // Control path: counters and pad drive.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      rstCnt           <= '0;
      mdcCnt           <= '0;
      bitCnt           <= '0;
      mdClkOut         <= 1'b0;
      mdioOut          <= 1'b1;
      mdioOeOut        <= 1'b0;
      cmdBus.rdDataOut <= '0;
    end else if (!mmcmLockedIn) begin
      rstCnt    <= '0;
      mdcCnt    <= '0;
      bitCnt    <= '0;
      mdClkOut  <= 1'b0;
      mdioOut   <= 1'b1;
      mdioOeOut <= 1'b0;
    end else begin
      unique case (state)
        RST_HOLD, RST_WAIT: rstCnt <= (nextState != state) ? '0 : rstCnt + 32'd1;
        IDLE: begin
          mdcCnt    <= '0;
          bitCnt    <= '0;
          mdClkOut  <= 1'b0;
          mdioOut   <= 1'b1;
          mdioOeOut <= cmdAccept;
        end
        PREAMBLE, FRAME: begin
          mdcCnt <= mdcTick ? '0 : mdcCnt + DIV_W'(1);
          if (mdcTick) mdClkOut <= ~mdClkOut;
          if (mdcFall) begin
            bitCnt <= bitCnt + 5'd1;
            if (state == PREAMBLE) begin
              if (bitCnt == 5'd31) mdioOut <= frameSr[31];
            end else if (bitCnt == 5'd31) begin
              mdioOut   <= 1'b1;
              mdioOeOut <= 1'b0;
              if (isRead) cmdBus.rdDataOut <= rdSr;
            end else begin
              mdioOut <= frameSr[31];
              // Bit 13 ending means TA is next: release the line for reads.
              if (isRead && bitCnt >= 5'd13) mdioOeOut <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Frame data: the outgoing shift register holds the next bit in [31].
  always_ff @(posedge clkIn) begin
    if (cmdAccept) begin
      isRead  <= ~cmdBus.cmdWriteIn;
      frameSr <= {2'b01,
                  cmdBus.cmdWriteIn ? 2'b01 : 2'b10,
                  cmdBus.cmdPhyAddrIn,
                  cmdBus.cmdRegAddrIn,
                  cmdBus.cmdWriteIn ? 2'b10 : 2'b11,
                  cmdBus.cmdWriteIn ? cmdBus.cmdWrDataIn : 16'hFFFF};
    end else if (mdcFall && (state == FRAME || (state == PREAMBLE && bitCnt == 5'd31))) begin
      frameSr <= {frameSr[30:0], 1'b1};
    end
    // Every frame bit is shifted in; the last 16 left are the read data.
    if (state == FRAME && mdcRise && isRead) rdSr <= {rdSr[14:0], mdioIn};
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) intSync <= 2'b11;
    else       intSync <= {intSync[0], intBIn};
  end

endmodule
